input_counter: RTL and testbench
================================

Name: input_counter

Overview:
- Input-side frame loader for the 64-point FFT processor; the write end of the frame interface whose read end is the output counter.
- Accepts one frame of 64 samples over a valid/ready handshake, generates the input buffer write address and write enable, and drives the input-path control lines.
- Issues a one-cycle start pulse to the FFT core once the frame is complete, then blocks further input until the core reports done.

Parameters:
- ADDR_W, 6, address width; frame length is 2**ADDR_W samples (64).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- din_valid  input  1  source has a sample this cycle
- din_ready  output  1  loader accepts a sample this cycle (registered)
- counter_i  output  ADDR_W  write address of the current sample (registered count)
- wr_en  output  1  input buffer write strobe
- in_ctrl_all_in  output  1  selects the external input path into the first stage
- hold_all_in  output  1  freezes the input delay lines
- start  output  1  frame-loaded pulse to the FFT core (registered)
- core_done  input  1  core has consumed the frame (pulse or level, sampled in WAIT only)
- overrun  output  1  sticky error: din_valid seen while din_ready low

Behaviour:
- Reset is asynchronous and active-high. While rst=1: state=IDLE, counter=0, din_ready=0, start=0, overrun=0.
- Combinational outputs during rst=1: wr_en=0, in_ctrl_all_in=0, hold_all_in=1.
- First rising clk edge with rst=0 sets din_ready=1.
- Accept: a sample is accepted on a rising edge where din_valid=1 and din_ready=1.
- wr_en = din_valid & din_ready, combinational, zero latency. counter_i is the address of that sample in the same cycle.
- hold_all_in = ~wr_en.
- in_ctrl_all_in = 1 in IDLE and LOAD, 0 in START and WAIT and under reset.
- IDLE: din_ready=1, counter=0. On accept: counter becomes 1, go to LOAD.
- LOAD:
  - Accept with counter<2**ADDR_W-1: counter+1, stay in LOAD.
  - Accept with counter=2**ADDR_W-1: counter wraps to 0, din_ready goes 0, start goes 1, go to START. All of these register on the same edge.
  - din_valid=0: counter holds. No timeout.
- START: start=1 for exactly this one cycle, din_ready=0. Go to WAIT unconditionally. core_done is ignored here.
- WAIT: din_ready=0, start=0. When core_done=1 at an edge: go to IDLE and set din_ready=1 on that edge.
- overrun: set at any edge (rst=0) where din_valid=1 and din_ready=0. Cleared only by rst.
- Latency: the start pulse is visible the cycle after the last (64th) accept. The minimum frame-to-frame gap is 2 cycles plus the core_done wait.
- Reset mid-frame discards the partial frame. Loading restarts at address 0.
- counter is ADDR_W bits wide, unsigned, and wraps modulo 2**ADDR_W.
- Unused 2-bit state encodings go to IDLE.

Test Plan:
- Reset: assert rst asynchronously mid-LOAD at counter_i=37 -> immediately counter_i=0, din_ready=0, hold_all_in=1, start=0, overrun=0. First edge after release -> din_ready=1.
- Continuous din_valid for 64 cycles -> wr_en high 64 cycles with counter_i 0..63. din_ready=0 and start=1 the following cycle. start=0 one cycle later. counter_i=0.
- din_valid every other cycle -> counter_i advances only on accepts. wr_en shows 64 pulses. start fires after the 64th accept, ~127 cycles after the first.
- din_valid held high through START and WAIT -> no wr_en, overrun=1 and stays 1 after the next frame completes, until rst.
- core_done pulsed in START (ignored, state stays WAIT), then in WAIT -> din_ready=1 next cycle. The next frame writes counter_i 0..63 and start pulses again.
- Two back-to-back frames with core_done tied high -> exactly 2 dead cycles (START, WAIT) between frames. wr_en count 128, start pulses 2, overrun=0 if din_valid respects din_ready.

Source files
------------

// File: rtl/input_counter.sv
// Input-side frame loader for the 64-point FFT: accepts one frame over valid/ready,
// generates buffer write address/strobe, pulses start and waits for core_done.
module input_counter #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              din_valid,
   output logic              din_ready,
   output logic [ADDR_W-1:0] counter_i,
   output logic              wr_en,
   output logic              in_ctrl_all_in,
   output logic              hold_all_in,
   output logic              start,
   input  logic              core_done,
   output logic              overrun
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_START = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] counter_q, counter_d;
   logic              din_ready_q, din_ready_d;
   logic              start_q, start_d;
   logic              overrun_q, overrun_d;
   logic              accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         counter_q   <= '0;
         din_ready_q <= 1'b0;
         start_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         counter_q   <= counter_d;
         din_ready_q <= din_ready_d;
         start_q     <= start_d;
         overrun_q   <= overrun_d;
      end
   end

   always_comb begin
      accept      = din_valid & din_ready_q;
      state_d     = state_q;
      counter_d   = counter_q;
      din_ready_d = din_ready_q;
      start_d     = 1'b0;
      overrun_d   = overrun_q | (din_valid & ~din_ready_q);

      case (state_q)
         S_IDLE: begin
            din_ready_d = 1'b1;
            counter_d   = '0;
            if (accept) begin
               counter_d = counter_q + 1'b1;
               state_d   = S_LOAD;
            end
         end
         S_LOAD: begin
            din_ready_d = 1'b1;
            if (accept) begin
               counter_d = counter_q + 1'b1;
               // Last sample: address wraps, ready drops and start rises on the same edge
               if (counter_q == LAST_ADDR) begin
                  din_ready_d = 1'b0;
                  start_d     = 1'b1;
                  state_d     = S_START;
               end
            end
         end
         S_START: begin
            din_ready_d = 1'b0;
            state_d     = S_WAIT;
         end
         S_WAIT: begin
            din_ready_d = 1'b0;
            if (core_done) begin
               din_ready_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            din_ready_d = 1'b0;
            counter_d   = '0;
            state_d     = S_IDLE;
         end
      endcase
   end

   assign din_ready      = din_ready_q;
   assign counter_i      = counter_q;
   assign start          = start_q;
   assign overrun        = overrun_q;
   assign wr_en          = din_valid & din_ready_q;
   assign hold_all_in    = ~wr_en;
   // Reset is gated in explicitly because the state register sits at IDLE under reset
   assign in_ctrl_all_in = ~rst & ((state_q == S_IDLE) | (state_q == S_LOAD));

endmodule

// File: tb/tb_input_counter.sv
// Scoreboard bench for input_counter: driver queues expected write addresses,
// a negedge monitor pops them on every wr_en and checks start timing.
module tb_input_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       din_valid = 1'b0;
   logic       core_done = 1'b0;
   logic       din_ready;
   logic [5:0] counter_i;
   logic       wr_en;
   logic       in_ctrl_all_in;
   logic       hold_all_in;
   logic       start;
   logic       overrun;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int wr_cnt = 0;
   int start_cnt = 0;
   int first_wr_cyc = -1;
   int start_cyc = -1;
   bit prev_last = 1'b0;
   logic [5:0] exp_q[$];

   input_counter #(.ADDR_W(6)) dut (
      .clk(clk),
      .rst(rst),
      .din_valid(din_valid),
      .din_ready(din_ready),
      .counter_i(counter_i),
      .wr_en(wr_en),
      .in_ctrl_all_in(in_ctrl_all_in),
      .hold_all_in(hold_all_in),
      .start(start),
      .core_done(core_done),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: every wr_en consumes one queued address; start must follow address 63 by one cycle
   initial forever begin
      logic [5:0] e;
      bit last;
      @(negedge clk);
      last = 1'b0;
      if (wr_en) begin
         wr_cnt++;
         if (exp_q.size() == 0) check("wr_en_unexpected", 1, 0);
         else begin
            e = exp_q.pop_front();
            check("wr_addr", counter_i, e);
            last = (e == 6'd63);
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
         end
      end
      if (!rst) check("start_timing", start, prev_last);
      if (start) begin
         start_cnt++;
         start_cyc = cyc;
      end
      prev_last = last;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_sample(input logic [5:0] idx, output int c);
      int t;
      t = 0;
      c = -1;
      while (!din_ready && t < 300) begin
         step();
         t++;
      end
      if (t >= 300) check("ready_timeout", 0, 1);
      else begin
         exp_q.push_back(idx);
         din_valid = 1'b1;
         c = cyc;
         step();
         din_valid = 1'b0;
      end
   endtask

   task automatic frame(input int gap, output int first_c, output int last_c);
      int c;
      first_c = -1;
      last_c = -1;
      for (int i = 0; i < 64; i++) begin
         push_sample(6'(i), c);
         if (i == 0) first_c = c;
         if (i == 63) last_c = c;
         if (i < 63) repeat (gap) step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int f1, l1, f2, l2, w0, s0;

      // Reset state, including combinational outputs with din_valid asserted
      #1 rst = 1'b1;
      din_valid = 1'b1;
      #1;
      check("rst_din_ready", din_ready, 0);
      check("rst_counter", counter_i, 0);
      check("rst_start", start, 0);
      check("rst_overrun", overrun, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_hold", hold_all_in, 1);
      check("rst_in_ctrl", in_ctrl_all_in, 0);
      din_valid = 1'b0;
      step();
      #2 rst = 1'b0;
      step();
      check("post_rst_ready", din_ready, 1);
      check("idle_in_ctrl", in_ctrl_all_in, 1);
      check("idle_hold", hold_all_in, 1);

      // Continuous frame
      frame(0, f1, l1);
      check("f1_start", start, 1);
      check("f1_ready", din_ready, 0);
      check("f1_counter", counter_i, 0);
      check("f1_in_ctrl", in_ctrl_all_in, 0);
      step();
      check("f1_start_off", start, 0);
      check("f1_wait_ready", din_ready, 0);
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      check("f1_done_ready", din_ready, 1);
      check("f1_wr_cnt", wr_cnt, 64);
      check("f1_start_cnt", start_cnt, 1);

      // Every-other-cycle frame, core_done pulsed during START
      first_wr_cyc = -1;
      frame(1, f1, l1);
      check("f2_start", start, 1);
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      check("f2_start_latency", start_cyc - first_wr_cyc, 127);
      check("f2_wait_ready", din_ready, 0);
      check("f2_wait_start", start, 0);
      repeat (2) step();
      check("f2_wait_ready_hold", din_ready, 0);
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      check("f2_done_ready", din_ready, 1);
      check("f2_wr_cnt", wr_cnt, 128);

      // din_valid held through START and WAIT sets sticky overrun
      frame(0, f1, l1);
      din_valid = 1'b1;
      check("ovr_no_wr_en", wr_en, 0);
      repeat (3) step();
      check("ovr_set", overrun, 1);
      check("ovr_ready", din_ready, 0);
      din_valid = 1'b0;
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      frame(0, f1, l1);
      step();
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      check("ovr_sticky", overrun, 1);
      check("ovr_start_cnt", start_cnt, 4);
      check("ovr_wr_cnt", wr_cnt, 256);

      // Asynchronous reset mid-frame at address 37
      for (int i = 0; i < 37; i++) push_sample(6'(i), f1);
      check("mid_counter", counter_i, 37);
      check("mid_in_ctrl", in_ctrl_all_in, 1);
      #2 rst = 1'b1;
      din_valid = 1'b1;
      #1;
      check("arst_counter", counter_i, 0);
      check("arst_ready", din_ready, 0);
      check("arst_hold", hold_all_in, 1);
      check("arst_start", start, 0);
      check("arst_overrun", overrun, 0);
      din_valid = 1'b0;
      step();
      check("arst_ready_held", din_ready, 0);
      #2 rst = 1'b0;
      step();
      check("arst_release_ready", din_ready, 1);
      check("arst_release_counter", counter_i, 0);

      // Back-to-back frames with core_done tied high
      w0 = wr_cnt;
      s0 = start_cnt;
      core_done = 1'b1;
      frame(0, f1, l1);
      frame(0, f2, l2);
      repeat (2) step();
      core_done = 1'b0;
      check("b2b_gap", f2 - l1, 3);
      check("b2b_wr_cnt", wr_cnt - w0, 128);
      check("b2b_start_cnt", start_cnt - s0, 2);
      check("b2b_overrun", overrun, 0);
      check("b2b_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
